// File: rtl/reg_serial_reader.sv
// reg_serial_reader: LSB-first serial read-out of an n-bit register over valid/ready; in clk, reset (sync active-low), start, d[n], sout_ready; out sout, sout_valid, busy, done; define REG_READER_PARITY_EN to append an even-parity bit
module reg_serial_reader #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] d,
    input  logic         sout_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         busy,
    output logic         done
);
    localparam int cw = n > 1 ? $clog2(n) : 1;
`ifdef REG_READER_PARITY_EN
    typedef enum logic [1:0] {st_idle, st_shift, st_parity, st_done} state_t;
    localparam state_t after_shift = st_parity;
`else
    typedef enum logic [1:0] {st_idle, st_shift, st_done} state_t;
    localparam state_t after_shift = st_done;
`endif
    state_t state_q, state_d;
    logic [n-1:0] sh_q;
    logic [cw-1:0] cnt_q;
    logic xfer, last;
    assign xfer = sout_valid && sout_ready;
    assign last = cnt_q == cw'(n - 1);
`ifdef REG_READER_PARITY_EN
    logic par_q;
    always_ff @(posedge clk)
        if (!reset)
            par_q <= 1'b0;
        else if (state_q == st_idle && start)
            par_q <= ^d;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= st_idle;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == st_idle && start) begin
                sh_q  <= d;
                cnt_q <= '0;
            end else if (state_q == st_shift && xfer) begin
                sh_q  <= sh_q >> 1;
                // holding at n-1 on exit keeps the count in range for n=1
                cnt_q <= last ? cnt_q : cnt_q + 1'b1;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_idle:   state_d = start ? st_shift : st_idle;
            st_shift:  state_d = (xfer && last) ? after_shift : st_shift;
`ifdef REG_READER_PARITY_EN
            st_parity: state_d = xfer ? st_done : st_parity;
`endif
            st_done:   state_d = st_idle;
            default:   state_d = st_idle;
        endcase
    end
    // outputs decode registered state only, so no input reaches them combinationally
    always_comb begin
`ifdef REG_READER_PARITY_EN
        sout_valid = state_q == st_shift || state_q == st_parity;
        sout       = state_q == st_shift ? sh_q[0] : state_q == st_parity ? par_q : 1'b0;
`else
        sout_valid = state_q == st_shift;
        sout       = state_q == st_shift ? sh_q[0] : 1'b0;
`endif
        busy = state_q != st_idle;
        done = state_q == st_done;
    end
endmodule

// File: tb/tb_reg_serial_reader.sv
// tb_reg_serial_reader: directed bench with a bit-queue reference model checked every cycle
module tb_reg_serial_reader;
`ifdef REG_READER_PARITY_EN
    localparam int par = 1;
`else
    localparam int par = 0;
`endif
    logic clk = 1'b0, reset = 1'b0, start = 1'b0, sout_ready = 1'b1;
    logic [31:0] d = '0;
    logic sout, sout_valid, busy, done;
    int total = 0, bad = 0;
    logic chk_en = 1'b0;
    logic q[$];
    logic m_done = 1'b0;

    reg_serial_reader #(.n(32)) dut (
        .clk(clk), .reset(reset), .start(start), .d(d), .sout_ready(sout_ready),
        .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: a stream is just a queue of bits still to transfer, then one done cycle
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (q.size() > 0) begin
            if (sout_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end else if (start) begin
            for (int i = 0; i < 32; i++) q.push_back(d[i]);
            if (par == 1) q.push_back(^d);
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("m_valid", {31'b0, sout_valid}, {31'b0, q.size() > 0});
        chk("m_sout", {31'b0, sout}, {31'b0, q.size() > 0 ? q[0] : 1'b0});
        chk("m_busy", {31'b0, busy}, {31'b0, q.size() > 0 || m_done});
        chk("m_done", {31'b0, done}, {31'b0, m_done});
    end

    // call right after a negedge; returns at the negedge of the first idle cycle
    task automatic stream(input logic [31:0] v, input int mode, output int dc,
                          output logic [31:0] got, output logic gp);
        int c, k;
        c = 0; k = 0; dc = 0; got = '0; gp = 1'b0;
        d = v; start = 1'b1; sout_ready = 1'b1;
        while (c < 200) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (mode == 2 && c == 5) begin d = '1; start = 1'b1; end
            sout_ready = mode == 1 ? c[0] : 1'b1;
            if (sout_valid && sout_ready) begin
                if (k < 32) got[k] = sout; else gp = sout;
                k++;
            end
            if (done && dc == 0) dc = c;
            if (dc != 0 && c == dc + 1) break;
        end
        if (c >= 200) chk("timeout", 32'(c), 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int dc;
        logic [31:0] got;
        logic gp;
        d = 32'hA5A5_0F01; start = 1'b1; reset = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_outs", {28'b0, sout, sout_valid, busy, done}, 32'd0);
        @(negedge clk);
        chk("rst_outs2", {28'b0, sout, sout_valid, busy, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("post_rst_valid", {31'b0, sout_valid}, 32'd1);
        chk("post_rst_bit0", {31'b0, sout}, 32'd1);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("post_rst_idle", {31'b0, busy}, 32'd0);

        stream(32'hA5A5_0F01, 0, dc, got, gp);
        chk("basic_low16", {16'b0, got[15:0]}, 32'h0000_0F01);
        chk("basic_data", got, 32'hA5A5_0F01);
        chk("basic_done_cyc", 32'(dc), 32'(33 + par));

        stream(32'hA5A5_0F01, 1, dc, got, gp);
        chk("bp_data", got, 32'hA5A5_0F01);
        chk("bp_done_cyc", 32'(dc), 32'(64 + 2 * par));

        stream(32'hA5A5_0F01, 2, dc, got, gp);
        chk("snap_data", got, 32'hA5A5_0F01);
        chk("snap_done_cyc", 32'(dc), 32'(33 + par));

        stream(32'h1234_5678, 0, dc, got, gp);
        chk("b2b_a", got, 32'h1234_5678);
        stream(32'h8000_0001, 0, dc, got, gp);
        chk("b2b_b", got, 32'h8000_0001);
        chk("b2b_done_cyc", 32'(dc), 32'(33 + par));

        d = 32'h0000_0F0F; start = 1'b1; sout_ready = 1'b1;
        repeat (11) @(negedge clk) start = 1'b0;
        chk("mid_bit10", {30'b0, sout_valid, sout}, 32'd3);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_rst_outs", {28'b0, sout, sout_valid, busy, done}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_done", {31'b0, done}, 32'd0);
        end
        stream(32'h0000_0F0E, 0, dc, got, gp);
        chk("fresh_data", got, 32'h0000_0F0E);

        stream(32'h0000_0007, 0, dc, got, gp);
        chk("par_data", got, 32'h0000_0007);
        chk("par_done_cyc", 32'(dc), 32'(33 + par));
        if (par == 1) chk("par_bit", {31'b0, gp}, 32'd1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
